// File: rtl/light_fade_controller.sv
// Light fade controller: button-stepped colour index with hold-to-repeat,
// palette lookup, white/colour select, dimming and master enable. The RGB
// output slews toward its target by at most FADE_STEP per channel on every
// fade tick, so colour changes appear as smooth cross-fades.
// No handshakes here: button is a synchronous level sampled every clock, and
// all outputs are registered and valid every cycle after reset.
module light_fade_controller #(
    parameter int CW          = 8,
    parameter int NUM_COLOURS = 6,
    parameter int HOLD_W      = 6,
    parameter int DIM_SHIFT   = 2,
    parameter int FADE_STEP   = 32,
    parameter int FADE_DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic              sel,
    input  logic              sys_on,
    input  logic              dim_lights,
    input  logic [HOLD_W-1:0] threshold,
    output logic [3*CW-1:0]   light,
    output logic [2:0]        colour_idx,
    output logic              fading
);

    // Prescaler is at least one bit wide so FADE_DIV=1 still elaborates;
    // in that case it sits at zero and every cycle is a tick.
    localparam int              PW       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(FADE_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NUM_COLOURS - 1);
    // Step is held at CW+1 bits so distance comparisons cannot wrap.
    localparam logic [CW:0]     STEP     = (CW + 1)'(FADE_STEP);
    localparam logic [3*CW-1:0] WHITE    = {(3 * CW){1'b1}};

    logic              button_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_inc;
    logic [HOLD_W-1:0] hold_next;
    logic [2:0]        idx_adv;
    logic [2:0]        idx_next;
    logic [PW-1:0]     prescaler;
    logic              tick;
    logic              rise;
    logic [3*CW-1:0]   base;
    logic [3*CW-1:0]   target;
    logic [3*CW-1:0]   light_next;

    // Palette entry k is built from code k+1: bit 2 = R, bit 1 = G, bit 0 = B.
    function automatic logic [3*CW-1:0] palette(input logic [2:0] idx);
        logic [2:0] code;
        code = idx + 3'd1;
        return {{CW{code[2]}}, {CW{code[1]}}, {CW{code[0]}}};
    endfunction

    // Move one channel toward its target by at most STEP, snapping when close.
    function automatic logic [CW-1:0] slew(input logic [CW-1:0] cur,
                                           input logic [CW-1:0] tgt);
        logic [CW:0] c;
        logic [CW:0] t;
        logic [CW:0] d;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        d = (t >= c) ? (t - c) : (c - t);
        if (d == '0) begin
            return cur;
        end else if (FADE_STEP == 0 || d <= STEP) begin
            return tgt;
        end else if (t > c) begin
            return CW'(c + STEP);
        end else begin
            return CW'(c - STEP);
        end
    endfunction

    assign rise     = button & ~button_q;
    assign hold_inc = hold_cnt + HOLD_W'(1);
    assign idx_adv  = (colour_idx == IDX_LAST) ? 3'd0 : colour_idx + 3'd1;
    assign tick     = (prescaler == PRE_LAST);

    // Index advance: first press steps immediately, holding repeats every
    // `threshold` cycles; a held button with threshold 0 keeps hold_cnt at 0.
    always_comb begin
        idx_next  = colour_idx;
        hold_next = '0;
        if (rise) begin
            idx_next = idx_adv;
        end else if (button && threshold != '0) begin
            if (hold_inc == threshold) begin
                idx_next = idx_adv;
            end else begin
                hold_next = hold_inc;
            end
        end
    end

    // Target colour: master enable, then white/palette select, then dimming.
    always_comb begin
        base = '0;
        if (sys_on) begin
            base = sel ? palette(colour_idx) : WHITE;
        end
        target = base;
        if (dim_lights && sys_on) begin
            for (int ch = 0; ch < 3; ch++) begin
                target[ch*CW +: CW] = base[ch*CW +: CW] >> DIM_SHIFT;
            end
        end
    end

    // Per-channel slew, applied only on fade ticks.
    always_comb begin
        light_next = light;
        if (tick) begin
            for (int ch = 0; ch < 3; ch++) begin
                light_next[ch*CW +: CW] = slew(light[ch*CW +: CW], target[ch*CW +: CW]);
            end
        end
    end

    // State registers; fading compares the new light against the live target.
    always_ff @(posedge clk) begin
        if (rst) begin
            button_q   <= 1'b0;
            hold_cnt   <= '0;
            colour_idx <= 3'd0;
            prescaler  <= '0;
            light      <= '0;
            fading     <= 1'b0;
        end else begin
            button_q   <= button;
            hold_cnt   <= hold_next;
            colour_idx <= idx_next;
            prescaler  <= tick ? '0 : prescaler + PW'(1);
            light      <= light_next;
            fading     <= (light_next != target);
        end
    end

endmodule
